fifo_frame_reader: RTL
======================

# fifo_frame_reader

Read-side consumer for the ladder-card `lpm_fifo` instances configured with `lpm_showahead = "OFF"`.

- Waits until a full frame of payload words is buffered in the FIFO.
- Drains the frame using the FIFO's one-cycle read latency.
- Emits a framed stream (header, payload, XOR trailer) on a valid/ready interface toward the readout link serializer.

## Interface

Parameters:
- `DATA_WIDTH`, 16: FIFO word width (matches `lpm_width`); must be ≥ 16.
- `USEDW_WIDTH`, 8: FIFO `usedw` width (matches `lpm_widthu`).
- `FRAME_WORDS`, 64: payload words per frame; legal range 1..2^USEDW_WIDTH.
- `HEADER_TAG`, 8'hA5: constant, DATA_WIDTH-8 bits wide, placed in the header's upper bits.

Ports:
- `clock`, in, 1: single clock for all logic.
- `aclr`, in, 1: asynchronous active-high reset.
- `enable`, in, 1: permits starting a new frame.
- `fifo_q`, in, DATA_WIDTH: FIFO read data, valid the cycle after `fifo_rdreq`.
- `fifo_empty`, in, 1: FIFO empty flag.
- `fifo_full`, in, 1: FIFO full flag.
- `fifo_usedw`, in, USEDW_WIDTH: FIFO occupancy; wraps to 0 when the FIFO is full.
- `fifo_rdreq`, out, 1: read request to the FIFO.
- `out_data`, out, DATA_WIDTH: framed output word.
- `out_valid`, out, 1: `out_data` valid.
- `out_ready`, in, 1: downstream accepts the word.
- `out_sof`, out, 1: marks the header word.
- `out_eof`, out, 1: marks the trailer word.
- `frame_count`, out, 16: count of completed frames.
- `busy`, out, 1: high when state ≠ IDLE or the output buffer is non-empty.

## Operation

**Output buffer (OB)**
- 2-entry FIFO of {data, sof, eof}.
- `out_data`, `out_sof` and `out_eof` come from the OB head; `out_valid` = OB non-empty.
- Pop = `out_valid && out_ready`.

**State machine: IDLE, PAYLOAD, TRAILER**

IDLE
- Start condition: `enable && (fifo_full || fifo_usedw >= FRAME_WORDS)`, and the OB has room after this cycle's pop.
- On start:
  - push header = {HEADER_TAG, seq[7:0]} with sof=1;
  - load req_left = recv_left = FRAME_WORDS;
  - clear checksum;
  - go to PAYLOAD.

PAYLOAD
- `fifo_rdreq` is combinational: `req_left != 0 && !fifo_empty && (ob_count + inflight - pop) < 2`.
- On each rdreq: decrement req_left; set inflight=1 for the next cycle.
- In the cycle after an rdreq:
  - push `fifo_q` (sof=0, eof=0);
  - checksum ^= `fifo_q`;
  - decrement recv_left.
- When recv_left reaches 0, go to TRAILER.

TRAILER
- When the OB has room: push checksum with eof=1, increment seq, go to IDLE.

**Counters and flags**
- `frame_count` increments when the trailer is popped; wraps 0xFFFF→0.
- seq is an internal 8-bit counter; wraps 255→0.
- `enable` only gates the start of a frame. Deasserting it mid-frame does not stop that frame.
- `fifo_empty` in PAYLOAD (upstream misbehaviour) stalls rdreq. Words are never read from an empty FIFO.

## Timing

**Reset values:** `fifo_rdreq`=0, `out_valid`=0, `out_data`=0, `out_sof`=0, `out_eof`=0, `frame_count`=0, `busy`=0. State=IDLE, seq=0, OB empty, inflight=0.

**Reset mid-frame:** `aclr` discards the partial frame immediately. No trailer is emitted, `frame_count` is unchanged from reset (0), and the FIFO is cleared by the same `aclr` at system level.

**Latency**
- Start condition true before edge k: header is visible with `out_valid`=1 after edge k.
- First rdreq can be high in the cycle after edge k; the first payload word is in the OB one edge after that rdreq edge.
- With `out_ready` held at 1, throughput is one word per cycle.
- A frame occupies FRAME_WORDS+2 output cycles.
- The next header can be pushed in the cycle after the trailer push, giving back-to-back frames.

**Handshake**
- `out_data`, `out_sof` and `out_eof` hold stable while `out_valid && !out_ready`.
- `out_valid` never drops without a pop.

**Bounds**
- ob_count + inflight ≤ 2 at all times, so the OB never overflows.
- `fifo_rdreq` is never asserted when `fifo_empty`=1 or in IDLE/TRAILER.

**usedw wrap:** FRAME_WORDS = 2^USEDW_WIDTH starts only via `fifo_full`.

## Test plan

- **Basic frame:** FRAME_WORDS=4, FIFO preloaded with 0x0001..0x0004, `enable`=1, `out_ready`=1 → output A500(sof), 0001, 0002, 0003, 0004, 0004(eof, XOR of payload); `frame_count`=1; exactly 4 rdreq pulses.
- **Backpressure:** same as basic frame, but `out_ready` toggles 1/0 each cycle → identical word sequence, no duplicates or drops, `out_data` stable while stalled, rdreq never issued when the OB is full.
- **Threshold:** FRAME_WORDS=4, `fifo_usedw`=3 with `enable`=1 → no header, `busy`=0. Raise `fifo_usedw` to 4 → header appears after the next edge.
- **Full wrap:** USEDW_WIDTH=2, FRAME_WORDS=4, `fifo_usedw`=0 and `fifo_full`=1 → frame starts and reads 4 words.
- **Enable and sequence:** drop `enable` during payload → frame completes with trailer and `frame_count` increments; no new frame starts while `enable`=0. Over 257 frames, the header seq field goes 00..FF then wraps to 00.
- **Reset mid-frame:** assert `aclr` after 2 payload words → all outputs return to reset values immediately; after release, the next frame header carries seq=00.

Source files
------------

// File: rtl/fifo_frame_reader.sv
// Read-side consumer for a non-showahead FIFO: waits for a complete frame, drains it with
// one-cycle read latency and emits header / payload / XOR trailer on a valid/ready stream.
module fifo_frame_reader #(
   parameter int                    DATA_WIDTH  = 16,
   parameter int                    USEDW_WIDTH = 8,
   parameter int                    FRAME_WORDS = 64,
   parameter logic [DATA_WIDTH-9:0] HEADER_TAG  = (DATA_WIDTH-8)'(8'hA5)
) (
   input  logic                   clock,
   input  logic                   aclr,
   input  logic                   enable,
   input  logic [DATA_WIDTH-1:0]  fifo_q,
   input  logic                   fifo_empty,
   input  logic                   fifo_full,
   input  logic [USEDW_WIDTH-1:0] fifo_usedw,
   output logic                   fifo_rdreq,
   output logic [DATA_WIDTH-1:0]  out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_sof,
   output logic                   out_eof,
   output logic [15:0]            frame_count,
   output logic                   busy
);
   // state     | meaning
   // S_IDLE    | waiting for a fully buffered frame and room in the output buffer
   // S_PAYLOAD | issuing FIFO reads and pushing the returned words
   // S_TRAILER | waiting for output-buffer room to push the XOR checksum

   localparam int CW = USEDW_WIDTH + 1;
   localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_PAYLOAD, S_TRAILER} state_t;

   state_t                state;
   logic [CW-1:0]         req_left;
   logic [CW-1:0]         recv_left;
   logic                  inflight;
   logic [DATA_WIDTH-1:0] checksum;
   logic [7:0]            seq;
   logic [DATA_WIDTH-1:0] ob_data [2];
   logic [1:0]            ob_sof;
   logic [1:0]            ob_eof;
   logic [1:0]            ob_count;

   logic                  pop;
   logic                  room;
   logic                  start;
   logic [2:0]            occ_after_pop;
   logic                  push;
   logic                  push_sof;
   logic                  push_eof;
   logic [DATA_WIDTH-1:0] push_data;

   assign out_valid = (ob_count != 2'd0);
   assign out_data  = ob_data[0];
   assign out_sof   = ob_sof[0];
   assign out_eof   = ob_eof[0];
   assign pop       = out_valid && out_ready;
   assign room      = (ob_count != 2'd2) || pop;
   assign busy      = (state != S_IDLE) || out_valid;

   // Counting the in-flight read keeps the two-entry buffer from ever overflowing.
   assign occ_after_pop = 3'(ob_count) + 3'(inflight) - 3'(pop);

   // usedw wraps to 0 at full, so a frame the size of the whole FIFO starts only via fifo_full.
   assign start = enable && (fifo_full || ({1'b0, fifo_usedw} >= FRAME_CNT)) && room;

   assign fifo_rdreq = (state == S_PAYLOAD) && (req_left != '0) && !fifo_empty &&
                       (occ_after_pop < 3'd2);

   always_comb begin
      push      = 1'b0;
      push_data = '0;
      push_sof  = 1'b0;
      push_eof  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               push      = 1'b1;
               push_data = {HEADER_TAG, seq};
               push_sof  = 1'b1;
            end
         end
         S_PAYLOAD: begin
            if (inflight) begin
               push      = 1'b1;
               push_data = fifo_q;
            end
         end
         S_TRAILER: begin
            if (room) begin
               push      = 1'b1;
               push_data = checksum;
               push_eof  = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or posedge aclr) begin
      if (aclr) begin
         state       <= S_IDLE;
         req_left    <= '0;
         recv_left   <= '0;
         inflight    <= 1'b0;
         checksum    <= '0;
         seq         <= '0;
         ob_data[0]  <= '0;
         ob_data[1]  <= '0;
         ob_sof      <= '0;
         ob_eof      <= '0;
         ob_count    <= '0;
         frame_count <= '0;
      end else begin
         inflight <= fifo_rdreq;
         if (fifo_rdreq)
            req_left <= req_left - CW'(1);

         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_PAYLOAD;
                  req_left  <= FRAME_CNT;
                  recv_left <= FRAME_CNT;
                  checksum  <= '0;
               end
            end
            S_PAYLOAD: begin
               if (inflight) begin
                  checksum  <= checksum ^ fifo_q;
                  recv_left <= recv_left - CW'(1);
                  if (recv_left == CW'(1))
                     state <= S_TRAILER;
               end
            end
            S_TRAILER: begin
               if (room) begin
                  seq   <= seq + 8'd1;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase

         // Slot 0 is the head; a pop shifts slot 1 forward.
         if (pop) begin
            ob_data[0] <= ob_data[1];
            ob_sof[0]  <= ob_sof[1];
            ob_eof[0]  <= ob_eof[1];
         end
         if (push) begin
            if (ob_count == 2'd0 || (ob_count == 2'd1 && pop)) begin
               ob_data[0] <= push_data;
               ob_sof[0]  <= push_sof;
               ob_eof[0]  <= push_eof;
            end else begin
               ob_data[1] <= push_data;
               ob_sof[1]  <= push_sof;
               ob_eof[1]  <= push_eof;
            end
         end
         ob_count <= ob_count + 2'(push) - 2'(pop);

         if (pop && ob_eof[0])
            frame_count <= frame_count + 16'd1;
      end
   end
endmodule
